// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction memory handshake, tracks the PC and resolves jump/branch redirects.
// Latency: a fetched word is registered on the acknowledging edge, so one instruction per cycle with a zero-wait memory.
// Backpressure: Freeze parks the stage in HOLD with the request dropped, and memory wait states raise FetchStall.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        Freeze,
    input  logic        Jump,
    input  logic        BrTaken,
    input  logic [15:0] JumpAddress,
    input  logic [15:0] BranchAddress,
    output logic        IMem_Req,
    output logic [15:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [15:0] IMem_Data,
    output logic [15:0] MemResult_Out,
    output logic [15:0] PCPlus2_Out,
    output logic        Instr_Valid,
    output logic        FetchStall,
    output logic        FlushOut
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] mem_q, mem_d;
    logic [15:0] pcp2_q, pcp2_d;
    logic        vld_q, vld_d;

    logic        redirect;
    logic [15:0] target_raw;
    logic [15:0] target;
    logic [15:0] pc_plus2;

    // A branch beats a simultaneous jump; targets are always halfword aligned.
    assign redirect   = Jump | BrTaken;
    assign target_raw = BrTaken ? BranchAddress : JumpAddress;
    assign target     = target_raw & 16'hFFFE;
    assign pc_plus2   = pc_q + 16'd2;

    // State, PC, pending redirect target and fetched-instruction registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            pend_q  <= 16'h0000;
            mem_q   <= 16'h0000;
            pcp2_q  <= 16'h0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            mem_q   <= mem_d;
            pcp2_q  <= pcp2_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic: redirects always win over Freeze; data acked under a redirect is dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        mem_d   = mem_q;
        pcp2_d  = pcp2_q;
        vld_d   = vld_q;
        case (state_q)
            START: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    vld_d = 1'b0;
                    if (IMem_Ack) begin
                        pc_d = target;
                    end else begin
                        // The request in flight must complete before the PC can move.
                        pend_d  = target;
                        state_d = DRAIN;
                    end
                end else if (IMem_Ack) begin
                    mem_d  = IMem_Data;
                    pcp2_d = pc_plus2;
                    vld_d  = 1'b1;
                    if (Freeze) begin
                        state_d = HOLD;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end else begin
                    vld_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    vld_d   = 1'b0;
                    state_d = FETCH;
                end else if (!Freeze) begin
                    pc_d    = pc_plus2;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                vld_d = 1'b0;
                if (redirect) begin
                    pend_d = target;
                end
                if (IMem_Ack) begin
                    // A redirect arriving on the ack edge is the newest one and wins.
                    pc_d    = redirect ? target : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // Memory handshake and IF/ID control outputs decode straight from the registers.
    always_comb begin
        IMem_Req      = (state_q == FETCH) || (state_q == DRAIN);
        IMem_Addr     = pc_q;
        FetchStall    = (state_q == FETCH) && !IMem_Ack;
        MemResult_Out = mem_q;
        PCPlus2_Out   = pcp2_q;
        Instr_Valid   = vld_q;
        FlushOut      = !vld_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed fetch/freeze/redirect/reset scenarios with a wait-state memory model.
// Latency: expected instructions are queued per scenario and popped by a monitor as each new valid word appears.
// Backpressure: Freeze and programmable memory wait states are driven by the stimulus process.
module tb_if_stage;

    logic        clk;
    logic        rest;
    logic        Freeze;
    logic        Jump;
    logic        BrTaken;
    logic [15:0] JumpAddress;
    logic [15:0] BranchAddress;
    logic        IMem_Req;
    logic [15:0] IMem_Addr;
    logic        IMem_Ack;
    logic [15:0] IMem_Data;
    logic [15:0] MemResult_Out;
    logic [15:0] PCPlus2_Out;
    logic        Instr_Valid;
    logic        FetchStall;
    logic        FlushOut;

    typedef struct packed {
        logic [15:0] dat;
        logic [15:0] pc2;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory model: acks after wait_states requested cycles, returns A000+addr.
    int   wait_states;
    int   wcnt;
    logic mem_on;
    logic force_ack;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rest         (rest),
        .Freeze       (Freeze),
        .Jump         (Jump),
        .BrTaken      (BrTaken),
        .JumpAddress  (JumpAddress),
        .BranchAddress(BranchAddress),
        .IMem_Req     (IMem_Req),
        .IMem_Addr    (IMem_Addr),
        .IMem_Ack     (IMem_Ack),
        .IMem_Data    (IMem_Data),
        .MemResult_Out(MemResult_Out),
        .PCPlus2_Out  (PCPlus2_Out),
        .Instr_Valid  (Instr_Valid),
        .FetchStall   (FetchStall),
        .FlushOut     (FlushOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign IMem_Ack  = force_ack | (mem_on & IMem_Req & (wcnt >= wait_states));
    assign IMem_Data = 16'hA000 + IMem_Addr;

    always @(posedge clk or negedge rest) begin
        if (!rest)                    wcnt <= 0;
        else if (IMem_Req && !IMem_Ack) wcnt <= wcnt + 1;
        else                          wcnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [15:0] p);
        exp_t e;
        e.dat = d;
        e.pc2 = p;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   {31'd0, IMem_Req},    32'd0);
        check({tag, "_addr"},  {16'd0, IMem_Addr},   32'h0000);
        check({tag, "_mem"},   {16'd0, MemResult_Out}, 32'h0000);
        check({tag, "_pcp2"},  {16'd0, PCPlus2_Out}, 32'h0000);
        check({tag, "_vld"},   {31'd0, Instr_Valid}, 32'd0);
        check({tag, "_stall"}, {31'd0, FetchStall},  32'd0);
        check({tag, "_flush"}, {31'd0, FlushOut},    32'd1);
    endtask

    // Monitor: pops one expectation whenever a new valid instruction appears.
    logic        prev_vld = 1'b0;
    logic [15:0] prev_pc2 = 16'h0000;
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (Instr_Valid && (!prev_vld || PCPlus2_Out != prev_pc2)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h/%h expected none", MemResult_Out, PCPlus2_Out);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", {16'd0, MemResult_Out}, {16'd0, e.dat});
                check("sb_pcp2", {16'd0, PCPlus2_Out},   {16'd0, e.pc2});
            end
        end
        prev_vld = Instr_Valid;
        prev_pc2 = PCPlus2_Out;
    end

    // Stimulus and directed checks.
    initial begin
        rest = 1'b1; Freeze = 1'b0; Jump = 1'b0; BrTaken = 1'b0;
        JumpAddress = 16'h0000; BranchAddress = 16'h0000;
        wait_states = 0; mem_on = 1'b0; force_ack = 1'b1;
        #1 rest = 1'b0;
        #2 check_reset_vals("rst0");

        // A stray ack during reset and START is ignored.
        cyc(); cyc();
        check("rst_ack_vld", {31'd0, Instr_Valid}, 32'd0);
        mem_on = 1'b1;
        rest   = 1'b1;
        #1 check("start_req", {31'd0, IMem_Req}, 32'd0);

        // Zero-wait streaming, then Freeze at PC 0006.
        push(16'hA000, 16'h0002); push(16'hA002, 16'h0004);
        push(16'hA004, 16'h0006); push(16'hA006, 16'h0008);
        cyc();
        check("e1_vld",  {31'd0, Instr_Valid}, 32'd0);
        check("e1_addr", {16'd0, IMem_Addr},   32'h0000);
        check("e1_req",  {31'd0, IMem_Req},    32'd1);
        force_ack = 1'b0;
        cyc();
        check("e2_addr", {16'd0, IMem_Addr},   32'h0002);
        check("e2_vld",  {31'd0, Instr_Valid}, 32'd1);
        cyc();
        check("e3_addr", {16'd0, IMem_Addr},   32'h0004);
        cyc();
        check("e4_addr", {16'd0, IMem_Addr},   32'h0006);
        Freeze = 1'b1;
        cyc();
        check("hold_req",  {31'd0, IMem_Req},   32'd0);
        check("hold_mem",  {16'd0, MemResult_Out}, 32'hA006);
        check("hold_pcp2", {16'd0, PCPlus2_Out}, 32'h0008);
        cyc();
        check("hold2_req", {31'd0, IMem_Req},    32'd0);
        check("hold2_vld", {31'd0, Instr_Valid}, 32'd1);
        check("hold2_mem", {16'd0, MemResult_Out}, 32'hA006);
        cyc();
        Freeze = 1'b0;
        cyc();
        check("unfreeze_addr", {16'd0, IMem_Addr}, 32'h0008);
        check("unfreeze_req",  {31'd0, IMem_Req},  32'd1);

        // Two wait states: one instruction per three cycles.
        push(16'hA008, 16'h000A); push(16'hA00A, 16'h000C);
        wait_states = 2;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ws_stall%0d", i), {31'd0, FetchStall},  (i % 3 != 2) ? 32'd1 : 32'd0);
            check($sformatf("ws_addr%0d", i),  {16'd0, IMem_Addr},   32'h8 + 32'(2 * (i / 3)));
            check($sformatf("ws_vld%0d", i),   {31'd0, Instr_Valid}, (i % 3 == 0) ? 32'd1 : 32'd0);
            cyc();
        end

        // Jump while the ack is still two cycles away: DRAIN then redirect.
        check("pre_jump_mem", {16'd0, MemResult_Out}, 32'hA00A);
        Jump = 1'b1; JumpAddress = 16'h1235;
        cyc();
        Jump = 1'b0;
        check("drain_req",   {31'd0, IMem_Req},    32'd1);
        check("drain_addr",  {16'd0, IMem_Addr},   32'h000C);
        check("drain_stall", {31'd0, FetchStall},  32'd0);
        check("drain_vld",   {31'd0, Instr_Valid}, 32'd0);
        cyc();
        check("drain2_addr", {16'd0, IMem_Addr}, 32'h000C);
        cyc();
        check("jump_addr", {16'd0, IMem_Addr},   32'h1234);
        check("jump_vld",  {31'd0, Instr_Valid}, 32'd0);
        wait_states = 0;

        // Jump and branch together: the branch target wins.
        push(16'hB234, 16'h1236);
        cyc();
        check("tgt_vld",  {31'd0, Instr_Valid}, 32'd1);
        check("tgt_addr", {16'd0, IMem_Addr},   32'h1236);
        Jump = 1'b1; JumpAddress = 16'h0100;
        BrTaken = 1'b1; BranchAddress = 16'h0200;
        cyc();
        check("both_addr", {16'd0, IMem_Addr},   32'h0200);
        check("both_vld",  {31'd0, Instr_Valid}, 32'd0);
        BrTaken = 1'b0; JumpAddress = 16'hFFFF;
        cyc();
        Jump = 1'b0;
        check("ffff_addr", {16'd0, IMem_Addr}, 32'hFFFE);

        // PC wrap at FFFE.
        push(16'h9FFE, 16'h0000); push(16'hA000, 16'h0002);
        cyc();
        check("wrap_pcp2", {16'd0, PCPlus2_Out},   32'h0000);
        check("wrap_addr", {16'd0, IMem_Addr},     32'h0000);
        check("wrap_mem",  {16'd0, MemResult_Out}, 32'h9FFE);
        cyc();
        check("post_wrap_addr", {16'd0, IMem_Addr}, 32'h0002);
        wait_states = 2;
        cyc();
        check("stall_vld",      {31'd0, Instr_Valid},  32'd0);
        check("stall_mem_hold", {16'd0, MemResult_Out}, 32'hA000);
        check("stall_flag",     {31'd0, FetchStall},   32'd1);

        // Reset mid-fetch: immediate reset values, restart at RESET_PC.
        rest = 1'b0;
        #1 check_reset_vals("rst1");
        cyc();
        check("rst1_hold_req", {31'd0, IMem_Req}, 32'd0);
        wait_states = 0;
        rest = 1'b1;
        push(16'hA000, 16'h0002); push(16'hA002, 16'h0004);
        cyc();
        check("restart_addr", {16'd0, IMem_Addr},   32'h0000);
        check("restart_req",  {31'd0, IMem_Req},    32'd1);
        check("restart_vld",  {31'd0, Instr_Valid}, 32'd0);
        cyc();
        check("restart_mem", {16'd0, MemResult_Out}, 32'hA000);
        Freeze = 1'b1;
        cyc();
        check("final_req", {31'd0, IMem_Req}, 32'd0);
        cyc(); cyc();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rest  in  1  asynchronous, active-low reset.
- Freeze  in  1  hazard freeze from downstream; hold PC and outputs.
- Jump  in  1  jump redirect from decode stage.
- BrTaken  in  1  branch-taken redirect from decode stage.
- JumpAddress  in  16  jump target.
- BranchAddress  in  16  branch target.
- IMem_Req  out  1  instruction memory request.
- IMem_Addr  out  16  instruction memory address.
- IMem_Ack  in  1  memory acknowledge; IMem_Data valid this cycle.
- IMem_Data  in  16  fetched instruction word.
- MemResult_Out  out  16  fetched instruction to the IF/ID register.
- PCPlus2_Out  out  16  address of fetched instruction + 2.
- Instr_Valid  out  1  MemResult_Out/PCPlus2_Out hold a valid instruction.
- FetchStall  out  1  fetch outstanding, no instruction yet; drives the IF/ID freeze.
- FlushOut  out  1  equals !Instr_Valid; drives the IF/ID flush.

Function
REQ-003 SHALL implement FSM states START, FETCH, HOLD, DRAIN.
REQ-004 SHALL leave START for FETCH on the first rising edge after rest deasserts.
REQ-005 FETCH SHALL assert IMem_Req=1 and IMem_Addr=PC, holding both stable until IMem_Ack.
REQ-006 In FETCH with IMem_Ack=1 and no redirect, SHALL register MemResult_Out=IMem_Data, PCPlus2_Out=PC+2, Instr_Valid=1 on that edge.
REQ-007 On the REQ-006 edge, if Freeze=0, SHALL set PC<=PC+2 and stay in FETCH; if Freeze=1, SHALL keep PC and enter HOLD.
REQ-008 In FETCH, IMem_Req SHALL be held through consecutive acks, giving one instruction per cycle with a zero-wait memory.
REQ-009 HOLD SHALL deassert IMem_Req and keep PC, MemResult_Out, PCPlus2_Out and Instr_Valid unchanged.
REQ-010 HOLD SHALL exit when Freeze=0, setting PC<=PC+2 and entering FETCH.
REQ-011 FetchStall SHALL be 1 exactly when state=FETCH and IMem_Ack=0, and 0 in all other states.
REQ-012 A redirect is Jump=1 or BrTaken=1.
REQ-013 If Jump=1 and BrTaken=1 in the same cycle, BrTaken SHALL win and the target SHALL be BranchAddress.
REQ-014 The target SHALL have bit 0 forced to 0.
REQ-015 A redirect in FETCH with IMem_Ack=1 SHALL discard IMem_Data, set Instr_Valid=0 and PC<=target, and stay in FETCH.
REQ-016 A redirect in FETCH with IMem_Ack=0 SHALL latch the target into a pending register and enter DRAIN.
REQ-017 DRAIN SHALL keep IMem_Req=1 with the old address until IMem_Ack.
REQ-018 On that IMem_Ack, DRAIN SHALL discard the data, set Instr_Valid=0 and PC<=pending target, and enter FETCH.
REQ-019 A redirect in HOLD SHALL set PC<=target and Instr_Valid=0 and enter FETCH regardless of Freeze.
REQ-020 A redirect arriving in DRAIN SHALL overwrite the pending target (the last one wins).
REQ-021 Redirect SHALL take priority over Freeze in every state.
REQ-022 PC+2 SHALL wrap modulo 2^16 (16'hFFFE+2 = 16'h0000).
REQ-023 Instr_Valid SHALL drop to 0 on any fetch edge that produces no instruction: a stall cycle, a discard, or DRAIN.
REQ-024 MemResult_Out and PCPlus2_Out SHALL hold their last values while Instr_Valid=0.

Reset
REQ-025 rest=0 SHALL immediately, without waiting for a clock edge:
- set state=START and PC=RESET_PC;
- drive IMem_Req=0 and IMem_Addr=RESET_PC;
- drive MemResult_Out=16'h0000, PCPlus2_Out=16'h0000, Instr_Valid=0, FetchStall=0, FlushOut=1;
- clear the pending target.
REQ-026 Reset asserted mid-fetch or mid-drain SHALL abandon the request; a later IMem_Ack SHALL be ignored until the block is back in FETCH.

Verification
REQ-027 Reset release, zero-wait memory returning 16'hA000+addr:
- response: IMem_Addr 0000,0002,0004 on consecutive cycles;
- MemResult_Out A000,A002,A004; PCPlus2_Out 0002,0004,0006; Instr_Valid=1 from the 2nd cycle after release.
REQ-028 Memory with 2 wait states:
- response: FetchStall=1 for 2 cycles per fetch; IMem_Addr stable; Instr_Valid=0 during the wait; one instruction per 3 cycles.
REQ-029 Freeze=1 for 3 cycles at PC=0006:
- response: HOLD; IMem_Req=0; outputs frozen;
- next fetch address is 0008 after Freeze drops.
REQ-030 Jump=1 with JumpAddress=16'h1235 while an ack is pending, ack 2 cycles later:
- response: DRAIN; the acked data is discarded (Instr_Valid=0);
- next IMem_Addr=16'h1234.
REQ-031 Jump=1 (JumpAddress=0100) and BrTaken=1 (BranchAddress=0200) in the same cycle:
- response: next IMem_Addr=0200.
REQ-032 Two boundary checks:
- PC=FFFE fetch: PCPlus2_Out=0000 and the next IMem_Addr=0000;
- rest pulsed low mid-fetch: outputs reach reset values immediately and fetch restarts at RESET_PC.
